// File: rtl/axis_eth_preamble_insert_64_if.sv
// AXI-stream bundle used on both sides of the preamble insert stage.
// Only the handshake/payload signals live here; clock and reset stay plain ports.
interface axis_eth_preamble_insert_64_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    // Source side drives payload and valid, sink side drives ready.
    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_eth_preamble_insert_64.sv
// Prepends one 8-byte preamble/SFD beat to every frame on a 64-bit AXI stream
// and holds off the next frame until a minimum inter-frame gap has elapsed.
// The gap is reduced by the unused byte lanes of each frame's last beat.
module axis_eth_preamble_insert_64 #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE   = 64'hD555555555555555
) (
    input  logic                          clk,
    input  logic                          rst,
    axis_eth_preamble_insert_64_if.slave  s_axis,
    axis_eth_preamble_insert_64_if.master m_axis,
    input  logic [7:0]                    cfg_ifg,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_IFG
    } state_t;

    state_t                state;

    // Single output register; it is the only storage on the data path.
    logic [DATA_WIDTH-1:0] out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_user;
    logic                  busy_q;

    // Gap bookkeeping: required gap, bytes counted so far, and whether
    // counting has begun (only after the last beat left on m_axis).
    logic [7:0]            ifg_g;
    logic [8:0]            ifg_cnt;
    logic                  ifg_run;

    logic                  load_en;
    logic                  s_hs;
    logic                  gap_done;
    logic                  start_pre;
    logic [9:0]            ifg_cnt_next;
    logic [3:0]            keep_cnt;
    logic [3:0]            unused_bytes;
    logic signed [8:0]     gap_diff;
    logic [7:0]            gap_bytes;

    assign load_en       = !out_valid || m_axis.tready;
    assign s_axis.tready = (state == ST_PAYLOAD) && load_en;
    assign s_hs          = s_axis.tvalid && s_axis.tready;
    assign ifg_cnt_next  = {1'b0, ifg_cnt} + 10'd8;

    // The current idle cycle is the last one the gap needs: either the gap is
    // zero and the last beat is leaving now, or this cycle's 8 bytes reach it.
    assign gap_done  = (state == ST_IFG) &&
                       ((!ifg_run && out_valid && m_axis.tready && (ifg_g == 8'd0)) ||
                        (ifg_run && (ifg_cnt_next >= {2'b00, ifg_g})));

    // A waiting frame gets its preamble as soon as the register is free and
    // no gap is owed, which lets a zero gap run frames back to back.
    assign start_pre = s_axis.tvalid && load_en && ((state == ST_IDLE) || gap_done);

    // Gap owed after the incoming last beat: cfg_ifg minus its unused lanes, floored at 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        keep_cnt = 4'd0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + 4'(s_axis.tkeep[i]);
        end
        unused_bytes = 4'(KEEP_WIDTH) - keep_cnt;
        gap_diff     = $signed({1'b0, cfg_ifg}) - $signed({5'b00000, unused_bytes});
        gap_bytes    = gap_diff[8] ? 8'd0 : gap_diff[7:0];
    end

    // Frame sequencer and output register: preamble, payload pass-through, gap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= ST_IDLE;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
            busy_q    <= 1'b0;
            ifg_g     <= 8'd0;
            ifg_cnt   <= 9'd0;
            ifg_run   <= 1'b0;
        end else if (start_pre) begin
            out_data  <= PREAMBLE;
            out_keep  <= '1;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
            out_valid <= 1'b1;
            busy_q    <= 1'b1;
            ifg_run   <= 1'b0;
            state     <= ST_PAYLOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_en) out_valid <= 1'b0;
                end

                ST_PAYLOAD: begin
                    if (s_hs) begin
                        out_data  <= s_axis.tdata;
                        out_keep  <= s_axis.tkeep;
                        out_last  <= s_axis.tlast;
                        out_user  <= s_axis.tuser & s_axis.tlast;
                        out_valid <= 1'b1;
                        if (s_axis.tlast) begin
                            ifg_g   <= gap_bytes;
                            ifg_cnt <= 9'd0;
                            ifg_run <= 1'b0;
                            state   <= ST_IFG;
                        end
                    end else if (load_en) begin
                        out_valid <= 1'b0;
                    end
                end

                ST_IFG: begin
                    if (load_en) out_valid <= 1'b0;
                    if (gap_done) begin
                        ifg_run <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (!ifg_run && out_valid && m_axis.tready) begin
                        ifg_run <= 1'b1;
                        ifg_cnt <= 9'd0;
                    end else if (ifg_run) begin
                        ifg_cnt <= ifg_cnt_next[8:0];
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = out_user;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_eth_preamble_insert_64.sv
// Directed bench for the 64-bit preamble insert stage: framing, gap lengths,
// error flag, output stalls and mid-frame reset.
module tb_axis_eth_preamble_insert_64;

    localparam logic [63:0] PRE = 64'hD555555555555555;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_ifg;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    axis_eth_preamble_insert_64_if s_if ();
    axis_eth_preamble_insert_64_if m_if ();

    axis_eth_preamble_insert_64 dut (
        .clk     (clk),
        .rst     (rst),
        .s_axis  (s_if),
        .m_axis  (m_if),
        .cfg_ifg (cfg_ifg),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] bd(input int fr, input int k);
        return {16'hF00D, 16'(fr), 16'hA5A5, 16'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [63:0] d, input logic [7:0] kp,
                          input logic l, input logic u);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tkeep  = kp;
        s_if.tlast  = l;
        s_if.tuser  = u;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                             input logic [7:0] kp, input logic l, input logic u);
        check({tag, "_valid"}, 64'(m_if.tvalid), 64'(v));
        if (v) begin
            check({tag, "_data"}, m_if.tdata, d);
            check({tag, "_keep"}, 64'(m_if.tkeep), 64'(kp));
            check({tag, "_last"}, 64'(m_if.tlast), 64'(l));
            check({tag, "_user"}, 64'(m_if.tuser), 64'(u));
        end
    endtask

    // Expect `idle` empty output cycles, then the preamble beat.
    task automatic wait_pre(input string tag, input int idle);
        for (int i = 0; i < idle; i++) begin
            tick();
            check($sformatf("%s_idle%0d_valid", tag, i), 64'(m_if.tvalid), 64'd0);
            check($sformatf("%s_idle%0d_busy", tag, i), 64'(busy), 64'd1);
        end
        tick();
        check_out({tag, "_pre"}, 1'b1, PRE, 8'hFF, 1'b0, 1'b0);
        check({tag, "_pre_busy"}, 64'(busy), 64'd1);
    endtask

    // Drive a frame's payload with m_axis_tready=1; the preamble is already on the output.
    task automatic send_beats(input int fr, input int nb, input logic [7:0] lkeep,
                              input logic luser, input int mid_k, input logic next_valid);
        for (int k = 0; k < nb; k++) begin
            logic       l;
            logic [7:0] kp;
            l  = (k == nb - 1);
            kp = l ? lkeep : 8'hFF;
            set_in(1'b1, bd(fr, k), kp, l, l ? luser : (k == mid_k));
            #1;
            check($sformatf("f%0d_b%0d_sready", fr, k), 64'(s_if.tready), 64'd1);
            tick();
            check_out($sformatf("f%0d_b%0d", fr, k), 1'b1, bd(fr, k), kp, l, l & luser);
        end
        set_in(next_valid, bd(fr + 1, 0), 8'hFF, 1'b0, 1'b0);
        #1;
        check($sformatf("f%0d_ifg_sready", fr), 64'(s_if.tready), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        cfg_ifg     = 8'd12;
        m_if.tready = 1'b1;
        set_in(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_mdata", m_if.tdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sready", 64'(s_if.tready), 64'd0);

        // Basic 64-byte frame, cfg_ifg=12 -> 2 idle cycles.
        set_in(1'b1, bd(1, 0), 8'hFF, 1'b0, 1'b0);
        wait_pre("f1", 0);
        send_beats(1, 8, 8'hFF, 1'b0, -1, 1'b1);
        wait_pre("f2", 2);

        // 61-byte frame (keep 0x1F): G=9 -> 2 idle cycles.
        send_beats(2, 8, 8'h1F, 1'b0, -1, 1'b1);
        wait_pre("f3", 2);

        // keep 0x0F: G=8 -> 1 idle cycle.
        send_beats(3, 8, 8'h0F, 1'b0, -1, 1'b1);
        wait_pre("f4", 1);

        // Zero IFG: next preamble right after the last-beat handshake.
        cfg_ifg = 8'd0;
        send_beats(4, 8, 8'hFF, 1'b0, -1, 1'b1);
        wait_pre("f5", 0);

        // Zero-byte last beat, tuser on a middle beat: G=12-8=4 -> 1 idle cycle.
        cfg_ifg = 8'd12;
        send_beats(5, 3, 8'h00, 1'b0, 1, 1'b1);
        wait_pre("f6", 1);

        // Error on last beat; cfg_ifg=2 with 4 unused lanes clamps G to 0.
        cfg_ifg = 8'd2;
        send_beats(6, 2, 8'h0F, 1'b1, -1, 1'b0);
        tick();
        check("f6_end_valid", 64'(m_if.tvalid), 64'd0);
        check("f6_end_busy", 64'(busy), 64'd0);

        // Back-pressure frame of 3 beats, cfg_ifg=8 -> G=8.
        cfg_ifg = 8'd8;
        set_in(1'b1, bd(7, 0), 8'hFF, 1'b0, 1'b0);
        tick();
        check_out("f7_pre", 1'b1, PRE, 8'hFF, 1'b0, 1'b0);
        m_if.tready = 1'b0;
        #1;
        check("f7_c1_sready", 64'(s_if.tready), 64'd0);
        tick();
        check_out("f7_c2_hold", 1'b1, PRE, 8'hFF, 1'b0, 1'b0);
        tick();
        check_out("f7_c3_hold", 1'b1, PRE, 8'hFF, 1'b0, 1'b0);
        m_if.tready = 1'b1;
        #1;
        check("f7_c3_sready", 64'(s_if.tready), 64'd1);
        tick();
        check_out("f7_b0", 1'b1, bd(7, 0), 8'hFF, 1'b0, 1'b0);
        set_in(1'b1, bd(7, 1), 8'hFF, 1'b0, 1'b0);
        tick();
        check_out("f7_b1", 1'b1, bd(7, 1), 8'hFF, 1'b0, 1'b0);
        set_in(1'b1, bd(7, 2), 8'hFF, 1'b1, 1'b0);
        m_if.tready = 1'b0;
        #1;
        check("f7_c5_sready", 64'(s_if.tready), 64'd0);
        tick();
        check_out("f7_b1_hold", 1'b1, bd(7, 1), 8'hFF, 1'b0, 1'b0);
        m_if.tready = 1'b1;
        tick();
        check_out("f7_b2", 1'b1, bd(7, 2), 8'hFF, 1'b1, 1'b0);
        set_in(1'b1, bd(8, 0), 8'hFF, 1'b0, 1'b0);
        m_if.tready = 1'b0;
        tick();
        check_out("f7_b2_hold1", 1'b1, bd(7, 2), 8'hFF, 1'b1, 1'b0);
        tick();
        check_out("f7_b2_hold2", 1'b1, bd(7, 2), 8'hFF, 1'b1, 1'b0);
        m_if.tready = 1'b1;
        wait_pre("f8", 1);

        // Reset after payload beat 3 (index 2) of frame 8.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, bd(8, k), 8'hFF, 1'b0, 1'b0);
            tick();
            check_out($sformatf("f8_b%0d", k), 1'b1, bd(8, k), 8'hFF, 1'b0, 1'b0);
        end
        set_in(1'b1, bd(8, 3), 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b1, bd(9, 0), 8'hFF, 1'b0, 1'b0);
        #1;
        check("midrst_mvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_mlast", 64'(m_if.tlast), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sready", 64'(s_if.tready), 64'd0);

        // Fresh frame after reset, then drain through a 12-byte gap.
        cfg_ifg = 8'd12;
        wait_pre("f9", 0);
        send_beats(9, 2, 8'hFF, 1'b0, -1, 1'b0);
        tick();
        check("f9_gap1_valid", 64'(m_if.tvalid), 64'd0);
        check("f9_gap1_busy", 64'(busy), 64'd1);
        tick();
        check("f9_gap2_busy", 64'(busy), 64'd1);
        tick();
        check("f9_idle_busy", 64'(busy), 64'd0);
        check("f9_idle_valid", 64'(m_if.tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
